// File: rtl/morse_encoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_encoder
// Purpose  : Sends one ASCII letter (A-Z, a-z) or a space as an on/off Morse
//            keying waveform with standard unit timing. Unsupported codes are
//            rejected with a one-cycle invalid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module morse_encoder #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       start,
    input  logic [7:0] ascii_in,
    output logic       morse_out,
    output logic       busy,
    output logic       done,
    output logic       invalid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MARK = 3'd1,
        S_EGAP = 3'd2,
        S_LGAP = 3'd3,
        S_WGAP = 3'd4
    } state_t;

    // Counter must reach 7 units - 1 (word gap), the longest interval.
    localparam int c_cnt_w = $clog2(7 * UNIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_end1 = c_cnt_w'(UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_end3 = c_cnt_w'(3 * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_end7 = c_cnt_w'(7 * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_len;
    logic [2:0]         r_idx;
    logic [3:0]         r_pat;     // first element in bit 3, 1 = dash
    logic               r_morse;
    logic               r_busy;
    logic               r_done;
    logic               r_invalid;

    logic [7:0]         w_char;
    logic [2:0]         w_len;
    logic [3:0]         w_pat;
    logic               w_letter;
    logic               w_space;
    logic [c_cnt_w-1:0] w_mark_end;
    logic [c_cnt_w-1:0] w_gap_end;

    // Fold lowercase to uppercase and look up the element length and pattern.
    always_comb begin
        w_char = ascii_in;
        if (ascii_in >= 8'h61 && ascii_in <= 8'h7A) begin
            w_char = ascii_in - 8'h20;
        end
        w_len = 3'd0;
        w_pat = 4'b0000;
        case (w_char)
            8'h41: {w_len, w_pat} = {3'd2, 4'b0100}; // A .-
            8'h42: {w_len, w_pat} = {3'd4, 4'b1000}; // B -...
            8'h43: {w_len, w_pat} = {3'd4, 4'b1010}; // C -.-.
            8'h44: {w_len, w_pat} = {3'd3, 4'b1000}; // D -..
            8'h45: {w_len, w_pat} = {3'd1, 4'b0000}; // E .
            8'h46: {w_len, w_pat} = {3'd4, 4'b0010}; // F ..-.
            8'h47: {w_len, w_pat} = {3'd3, 4'b1100}; // G --.
            8'h48: {w_len, w_pat} = {3'd4, 4'b0000}; // H ....
            8'h49: {w_len, w_pat} = {3'd2, 4'b0000}; // I ..
            8'h4A: {w_len, w_pat} = {3'd4, 4'b0111}; // J .---
            8'h4B: {w_len, w_pat} = {3'd3, 4'b1010}; // K -.-
            8'h4C: {w_len, w_pat} = {3'd4, 4'b0100}; // L .-..
            8'h4D: {w_len, w_pat} = {3'd2, 4'b1100}; // M --
            8'h4E: {w_len, w_pat} = {3'd2, 4'b1000}; // N -.
            8'h4F: {w_len, w_pat} = {3'd3, 4'b1110}; // O ---
            8'h50: {w_len, w_pat} = {3'd4, 4'b0110}; // P .--.
            8'h51: {w_len, w_pat} = {3'd4, 4'b1101}; // Q --.-
            8'h52: {w_len, w_pat} = {3'd3, 4'b0100}; // R .-.
            8'h53: {w_len, w_pat} = {3'd3, 4'b0000}; // S ...
            8'h54: {w_len, w_pat} = {3'd1, 4'b1000}; // T -
            8'h55: {w_len, w_pat} = {3'd3, 4'b0010}; // U ..-
            8'h56: {w_len, w_pat} = {3'd4, 4'b0001}; // V ...-
            8'h57: {w_len, w_pat} = {3'd3, 4'b0110}; // W .--
            8'h58: {w_len, w_pat} = {3'd4, 4'b1001}; // X -..-
            8'h59: {w_len, w_pat} = {3'd4, 4'b1011}; // Y -.--
            8'h5A: {w_len, w_pat} = {3'd4, 4'b1100}; // Z --..
            default: {w_len, w_pat} = {3'd0, 4'b0000};
        endcase
        w_letter = (w_len != 3'd0);
        w_space  = (ascii_in == 8'h20);
    end

    // Terminal counts for the current mark and the current trailing gap.
    always_comb begin
        w_mark_end = r_pat[3] ? c_end3 : c_end1;
        w_gap_end  = (r_state == S_WGAP) ? c_end7 : c_end3;
    end

    // Keying state machine; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= 3'd0;
            r_idx     <= 3'd0;
            r_pat     <= 4'b0000;
            r_morse   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_invalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_letter) begin
                            r_state <= S_MARK;
                            r_len   <= w_len;
                            r_pat   <= w_pat;
                            r_idx   <= 3'd0;
                            r_cnt   <= '0;
                            r_morse <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_space) begin
                            r_state <= S_WGAP;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_invalid <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (r_cnt == w_mark_end) begin
                        r_cnt   <= '0;
                        r_morse <= 1'b0;
                        r_pat   <= {r_pat[2:0], 1'b0};
                        if (r_idx == r_len - 3'd1) begin
                            r_state <= S_LGAP;
                        end else begin
                            r_state <= S_EGAP;
                            r_idx   <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                S_EGAP: begin
                    if (r_cnt == c_end1) begin
                        r_cnt   <= '0;
                        r_morse <= 1'b1;
                        r_state <= S_MARK;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                S_LGAP, S_WGAP: begin
                    if (r_cnt == w_gap_end) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_len   <= 3'd0;
                        r_idx   <= 3'd0;
                        r_pat   <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_morse <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign morse_out = r_morse;
    assign busy      = r_busy;
    assign done      = r_done;
    assign invalid   = r_invalid;

endmodule
`default_nettype wire
